fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 halted  in  1  core halted; no new fetch requests are issued.
REQ-006 stall  in  1  decode stall; the IF/ID register holds.
REQ-007 jump_d  in  1  decode-resolved jump taken.
REQ-008 pc_imm_d  in  32  jump target from decode.
REQ-009 branch_e  in  1  execute-resolved branch or jump redirect.
REQ-010 pc_branch_e  in  32  redirect target from execute.
REQ-011 imem_req  out  1  instruction-memory request valid.
REQ-012 imem_addr  out  32  request address, word aligned.
REQ-013 imem_ready  in  1  memory accepts the request this cycle.
REQ-014 imem_rvalid  in  1  response valid.
REQ-015 imem_rdata  in  32  response instruction.
REQ-016 instr_d  out  32  IF/ID instruction, registered.
REQ-017 pc_d  out  32  IF/ID PC, registered.
REQ-018 flush_d  out  1  flushes decode; combinationally equal to branch_e.

Function
REQ-019 FSM states: REQ (request pending issue), WAIT (one request outstanding), HOLD (response buffered while stalled).
REQ-020 Outstanding requests: at most one at any time.
REQ-021 In REQ with halted=0, imem_req=1 and imem_addr=pc_f.
- On imem_ready: latch pc_f as issued PC, go to WAIT.
REQ-022 In WAIT, imem_req=0.
- On imem_rvalid with drop=0 and stall=0: IF/ID <= {imem_rdata, issued PC}; pc_f <= issued PC+4 (mod 2^32); go to REQ.
REQ-023 In WAIT, on imem_rvalid with drop=0 and stall=1: capture imem_rdata and issued PC into the hold buffer; go to HOLD.
REQ-024 In HOLD, imem_req=0.
- When stall=0: IF/ID <= hold buffer; pc_f <= held PC+4; go to REQ.
REQ-025 Cycles with stall=0 and no instruction delivered load IF/ID with NOP_INSTR; pc_d keeps its previous value.
REQ-026 stall=1 holds instr_d and pc_d unchanged.
REQ-027 Redirect priority: branch_e, then jump_d&~stall; jump_d with stall=1 is ignored.
REQ-028 On redirect:
- pc_f <= target with bits[1:0] forced to 0.
- IF/ID <= NOP_INSTR next cycle, overriding stall.
- HOLD: buffer discarded, go to REQ.
- WAIT: set drop=1.
- REQ: the current-cycle handshake, if any, is cancelled (imem_req forced to 0 that cycle).
REQ-029 In WAIT with drop=1, imem_rvalid discards the response, clears drop, and goes to REQ without changing pc_f.
REQ-030 Redirect coincident with imem_rvalid in WAIT discards that response and goes to REQ; drop is not set.
REQ-031 halted=1 forces imem_req=0.
- An outstanding request completes normally.
- FSM stays in REQ until halted=0.

Reset
REQ-032 With rst_n=0 at a clock edge:
- pc_f=RESET_PC; state=REQ; drop=0; hold buffer cleared.
- instr_d=NOP_INSTR; pc_d=RESET_PC.
REQ-033 imem_req=0 while rst_n=0; asserting reset while in WAIT abandons the outstanding response.
- A late imem_rvalid after reset is ignored only if drop was set; memory must be reset together with this block.

Verification
REQ-034 Zero-wait memory (ready=1, rvalid the cycle after accept) -> one instruction per 2 cycles; pc_d sequence 0,4,8; NOP bubble between deliveries.
REQ-035 Response 0x00A00093 at PC 0x10 while stall=1 for 3 cycles -> state HOLD; instr_d unchanged; on stall release, instr_d=0x00A00093 and pc_d=0x10.
REQ-036 branch_e=1, pc_branch_e=0x200 in WAIT -> flush_d=1; next instr_d=NOP; stale response dropped; next imem_addr=0x200.
REQ-037 jump_d=1, pc_imm_d=0x103 with stall=1 -> ignored; same with stall=0 -> next imem_addr=0x100.
REQ-038 branch_e and jump_d asserted together -> branch target wins.
REQ-039 halted=1 in REQ -> imem_req stays 0 until halted=0; rst_n=0 mid-WAIT -> instr_d=NOP and imem_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// delivers responses into the IF/ID register, and handles decode/execute redirects.
// Latency: one cycle from accepted request to earliest response; IF/ID is registered.
// Backpressure: decode stall parks a response in a one-entry hold buffer; halted stops new requests.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   halted                     suppress new fetch requests
//   stall                      decode stall, IF/ID holds
//   jump_d, pc_imm_d           decode-resolved jump and its target
//   branch_e, pc_branch_e      execute-resolved redirect and its target (highest priority)
//   imem_req/addr/ready        request channel to instruction memory
//   imem_rvalid/rdata          response channel from instruction memory
//   instr_d, pc_d              IF/ID register outputs
//   flush_d                    decode flush, mirrors branch_e
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halted,
  input  logic        stall,
  input  logic        jump_d,
  input  logic [31:0] pc_imm_d,
  input  logic        branch_e,
  input  logic [31:0] pc_branch_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        flush_d
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc_f,       w_pc_f_nxt;
  logic [31:0] r_issued_pc,  w_issued_pc_nxt;
  logic        r_drop,       w_drop_nxt;
  logic [31:0] r_hold_instr, w_hold_instr_nxt;
  logic [31:0] r_hold_pc,    w_hold_pc_nxt;
  logic [31:0] r_instr_d,    w_instr_d_nxt;
  logic [31:0] r_pc_d,       w_pc_d_nxt;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_accept;

  // A decode jump is only trusted when decode is actually advancing.
  assign w_redirect   = branch_e | (jump_d & ~stall);
  assign w_target_raw = branch_e ? pc_branch_e : pc_imm_d;
  assign w_target     = {w_target_raw[31:2], 2'b00};

  // A redirect in REQ cancels this cycle's handshake so the stale PC never goes out.
  assign imem_req  = (r_state == S_REQ) & ~halted & ~w_redirect & rst_n;
  assign imem_addr = r_pc_f;
  assign w_accept  = imem_req & imem_ready;

  assign flush_d = branch_e;
  assign instr_d = r_instr_d;
  assign pc_d    = r_pc_d;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_f_nxt       = r_pc_f;
    w_issued_pc_nxt  = r_issued_pc;
    w_drop_nxt       = r_drop;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    // Without a delivery, a non-stalled decode sees a bubble; pc_d is left alone.
    w_instr_d_nxt    = stall ? r_instr_d : NOP_INSTR;
    w_pc_d_nxt       = r_pc_d;

    case (r_state)
      S_REQ: begin
        if (w_redirect) begin
          w_pc_f_nxt = w_target;
        end else if (w_accept) begin
          w_issued_pc_nxt = r_pc_f;
          w_state_nxt     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
          w_drop_nxt  = 1'b0;
          if (w_redirect) begin
            // Response arriving with the redirect is simply discarded; nothing left to drop.
            w_pc_f_nxt = w_target;
          end else if (!r_drop) begin
            if (stall) begin
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc_nxt    = r_issued_pc;
              w_state_nxt      = S_HOLD;
            end else begin
              w_instr_d_nxt = imem_rdata;
              w_pc_d_nxt    = r_issued_pc;
              w_pc_f_nxt    = r_issued_pc + 32'd4;
            end
          end
          // r_drop set: response belongs to a squashed path, pc_f already redirected.
        end else if (w_redirect) begin
          w_pc_f_nxt = w_target;
          w_drop_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          w_pc_f_nxt  = w_target;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_instr_d_nxt = r_hold_instr;
          w_pc_d_nxt    = r_hold_pc;
          w_pc_f_nxt    = r_hold_pc + 32'd4;
          w_state_nxt   = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // Redirect squashes whatever decode holds, even under stall.
    if (w_redirect) begin
      w_instr_d_nxt = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc_f       <= RESET_PC;
      r_issued_pc  <= RESET_PC;
      r_drop       <= 1'b0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_pc_f       <= w_pc_f_nxt;
      r_issued_pc  <= w_issued_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_instr_d    <= w_instr_d_nxt;
      r_pc_d       <= w_pc_d_nxt;
    end
  end

endmodule
